// File: rtl/scratch_pad_pkg.sv
// rtl/scratch_pad_pkg.sv - shared types and constants for the scratch-pad reader
package scratch_pad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int LAYER_BEATS = 2;
  localparam int ADDR_W      = 3;

  // Address of beat idx within a burst starting at layer base; wraps across the 8-entry port.
  function automatic logic [ADDR_W-1:0] beat_addr(input logic [1:0] base, input logic [3:0] idx);
    return ADDR_W'(LAYER_BEATS * int'(base) + int'(idx));
  endfunction

endpackage

// File: rtl/scratch_pad_reader_if.sv
// rtl/scratch_pad_reader_if.sv - buffered operand stream toward the NDP unit
interface scratch_pad_reader_if #(
  parameter int A_W = 64,
  parameter int B_W = 4096
);

  logic [A_W-1:0] out_a;
  logic [B_W-1:0] out_b;
  logic           out_valid;
  logic           out_ready;
  logic           out_last;

  modport master (output out_a, out_b, out_valid, out_last, input out_ready);
  modport slave  (input out_a, out_b, out_valid, out_last, output out_ready);

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with arbitrary depth and occupancy count
module sync_fifo #(
  parameter int  DW    = 8,
  parameter int  DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          wr_en_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          rd_en_i,
  output logic [DW-1:0] rd_data_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          do_wr, do_rd;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_wr = wr_en_i && (count_q != CW'(DEPTH));
  assign do_rd = rd_en_i && (count_q != '0);

  always_comb begin
    count_d = count_q;
    if (do_wr && !do_rd) begin
      count_d = count_q + CW'(1);
    end else if (do_rd && !do_wr) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= bump(wr_ptr_q);
      if (do_rd) rd_ptr_q <= bump(rd_ptr_q);
      count_q <= count_d;
    end
  end

  // Storage carries no reset; only the pointers and count define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;

endmodule

// File: rtl/scratch_pad_reader.sv
// rtl/scratch_pad_reader.sv - issues layer reads on scratch-pad port B and buffers
// the returned operands into a flow-controlled stream.
module scratch_pad_reader
  import scratch_pad_pkg::*;
#(
  parameter int  WIDTH        = 16,
  parameter int  SYS_WIDTH    = 64,
  parameter int  SYS_HEIGHT   = 1,
  parameter int  ARR_WIDTH    = 4,
  parameter int  ARR_HEIGHT   = 4,
  parameter int  READ_LATENCY = 2,
  parameter int  BUFFER_SIZE  = 5,
  localparam int A_W          = ARR_HEIGHT * SYS_HEIGHT * WIDTH,
  localparam int B_W          = ARR_WIDTH * SYS_WIDTH * WIDTH
) (
  input  logic              read_clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        layer_base,
  input  logic [2:0]        layer_count,
  output logic [ADDR_W-1:0] data_address_into_ndp_unit,
  input  logic [A_W-1:0]    data_in_a,
  input  logic [B_W-1:0]    data_in_b,
  output logic              busy,
  output logic              done,
  scratch_pad_reader_if.master out_if
);

  localparam int CNT_W  = $clog2(BUFFER_SIZE + 1);
  localparam int FIFO_W = A_W + B_W + 1;

  state_e                  state_q, state_d;
  logic [1:0]              base_q;
  logic [3:0]              total_q, issued_q;
  logic [ADDR_W-1:0]       addr_q;
  logic                    rd_vld_q, rd_last_q;
  logic [READ_LATENCY-1:0] vld_sr_q, last_sr_q;

  logic [CNT_W-1:0]        fifo_count;
  logic                    fifo_empty;
  logic [FIFO_W-1:0]       head;
  logic [7:0]              inflight;
  logic                    issue, final_issue, push, pop, drained;

  // rd_vld_q marks a fresh address on the port; vld_sr_q follows it through the read latency.
  always_comb begin
    inflight = 8'(rd_vld_q);
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight = inflight + 8'(vld_sr_q[i]);
    end
  end

  assign issue       = (state_q == ST_ISSUE) && (issued_q < total_q)
                       && ((8'(fifo_count) + inflight) < 8'(BUFFER_SIZE));
  assign final_issue = issue && ((issued_q + 4'd1) == total_q);
  assign push        = vld_sr_q[READ_LATENCY-1];
  assign pop         = !fifo_empty && out_if.out_ready;
  assign drained     = (inflight == 8'd0)
                       && ((fifo_count == '0) || ((fifo_count == CNT_W'(1)) && pop));

  always_comb begin
    state_d = state_q;
    busy    = 1'b1;
    done    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_d = (layer_count == 3'd0) ? ST_DONE : ST_ISSUE;
      end
      ST_ISSUE: begin
        if (final_issue) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (drained) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge read_clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      base_q    <= '0;
      total_q   <= '0;
      issued_q  <= '0;
      addr_q    <= '0;
      rd_vld_q  <= 1'b0;
      rd_last_q <= 1'b0;
      vld_sr_q  <= '0;
      last_sr_q <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == ST_IDLE) && start) begin
        base_q   <= layer_base;
        total_q  <= 4'(LAYER_BEATS * int'(layer_count));
        issued_q <= '0;
      end else if (issue) begin
        addr_q   <= beat_addr(base_q, issued_q);
        issued_q <= issued_q + 4'd1;
      end
      rd_vld_q  <= issue;
      rd_last_q <= final_issue;
      vld_sr_q  <= (vld_sr_q << 1) | READ_LATENCY'(rd_vld_q);
      last_sr_q <= (last_sr_q << 1) | READ_LATENCY'(rd_last_q);
    end
  end

  sync_fifo #(
    .DW    (FIFO_W),
    .DEPTH (BUFFER_SIZE)
  ) u_fifo (
    .clk_i     (read_clk),
    .rst_ni    (rst_n),
    .wr_en_i   (push),
    .wr_data_i ({last_sr_q[READ_LATENCY-1], data_in_a, data_in_b}),
    .rd_en_i   (pop),
    .rd_data_o (head),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  assign data_address_into_ndp_unit = addr_q;
  assign out_if.out_valid = !fifo_empty;
  assign out_if.out_last  = !fifo_empty && head[FIFO_W-1];
  assign out_if.out_a     = head[A_W+B_W-1 -: A_W];
  assign out_if.out_b     = head[B_W-1:0];

endmodule

// File: doc/scratch_pad_reader.md
SCRATCH_PAD_READER -- requirements
Module: scratch_pad_reader

Interface
REQ-001 SHALL have parameters: WIDTH 16, data element width; SYS_WIDTH 64 and SYS_HEIGHT 1, PEs per systolic array; ARR_WIDTH 4 and ARR_HEIGHT 4, arrays per dimension; READ_LATENCY 2, scratch-pad port-B read latency in cycles; BUFFER_SIZE 5, output FIFO depth in entries.
REQ-002 SHALL have exactly one clock and a synchronous, active-low reset: read_clk, input, 1, clock, all logic on its rising edge; rst_n, input, 1, synchronous active-low reset.
REQ-003 SHALL have start, input, 1, one-cycle request to begin a read burst.
REQ-004 SHALL have layer_base, input, 2, first layer to read, sampled on an accepted start.
REQ-005 SHALL have layer_count, input, 3, number of layers to read (0..4), sampled on an accepted start.
REQ-006 SHALL have data_address_into_ndp_unit, output, 3, scratch-pad port-B read address.
REQ-007 SHALL have data_in_a, input, ARR_HEIGHT*SYS_HEIGHT*WIDTH, and data_in_b, input, ARR_WIDTH*SYS_WIDTH*WIDTH, scratch-pad port-B read data.
REQ-008 SHALL have out_a and out_b, output, same widths as data_in_a and data_in_b, the buffered operands toward the NDP unit.
REQ-009 SHALL have out_valid, output, 1, and out_ready, input, 1, the output handshake; out_last, output, 1, marks the final beat of a burst.
REQ-010 SHALL have busy, output, 1, burst in progress, and done, output, 1, one-cycle end-of-burst pulse.

Function
REQ-011 SHALL implement the FSM IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
REQ-012 IDLE: start=1 SHALL latch layer_base and layer_count and enter ISSUE; if layer_count=0, SHALL enter DONE directly.
REQ-013 ISSUE SHALL issue 2*layer_count reads in order: address = (2*layer + beat) mod 8, beat 0 then 1, layer running from layer_base to layer_base+layer_count-1.
REQ-014 A read SHALL be issued in a cycle only when (FIFO occupancy + reads in flight) < BUFFER_SIZE; otherwise data_address_into_ndp_unit SHALL hold its value and no read is counted.
REQ-015 Issue tracking SHALL use a READ_LATENCY-deep valid shift register; the data present READ_LATENCY cycles after an issue SHALL be written into the FIFO, tagged with a last bit on the final read.
REQ-016 After the final issue, the FSM SHALL enter DRAIN and remain there until the in-flight count is 0 and the FIFO is empty.
REQ-017 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-018 busy SHALL be 1 in ISSUE, DRAIN and DONE, and 0 in IDLE.
REQ-019 start SHALL be ignored when not in IDLE.
REQ-020 out_valid SHALL equal FIFO non-empty; out_a, out_b and out_last SHALL reflect the FIFO head; an entry SHALL pop only when out_valid and out_ready are both 1.
REQ-021 A push and a pop in the same cycle SHALL leave occupancy unchanged; the FIFO SHALL never overflow, guaranteed by REQ-014.
REQ-022 Issue-to-out_valid latency with an empty FIFO SHALL be READ_LATENCY+1 cycles.
REQ-023 With out_ready held 1, issue SHALL sustain one read per cycle.
REQ-024 A layer_base + layer_count exceeding 4 SHALL wrap modulo 8, with no error flag.

Reset
REQ-025 rst_n=0 on a clock edge SHALL, in any state including mid-burst, force IDLE, clear the FIFO, in-flight tracking and counters, and drive out_valid=0, out_last=0, busy=0, done=0 and data_address_into_ndp_unit=0; out_a and out_b are don't-care.

Structure
REQ-026 The FSM state encoding and a LAYER_BEATS=2 constant SHALL reside in a shared package, scratch_pad_pkg.
REQ-027 The FIFO SHALL be a sub-module, sync_fifo, parameterised by data width and BUFFER_SIZE, with count output.

Verification
REQ-028 Reset, then start with base=0, count=2 and out_ready=1: addresses 0,1,2,3 on consecutive cycles; 4 beats out; out_last on beat 4; done one cycle after the last pop.
REQ-029 Start with count=0: done pulses within 2 cycles; out_valid never asserts; no address change.
REQ-030 Count=4 with out_ready=0: exactly 5 reads issued, then address holds; on raising out_ready, all 8 beats delivered in order with no loss or duplication.
REQ-031 Base=3, count=2: addresses 6,7,0,1.
REQ-032 Assert rst_n=0 mid-ISSUE: next cycle busy=0 and out_valid=0; a new start then completes normally.
REQ-033 Pulse start during DRAIN: ignored, and the burst count is unchanged.
